// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
// Holds the arbiter state encoding, default-configuration widths and index helpers.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arbState_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 4;

  // Width of an index/counter able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2Min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W  = clog2Min1(NUM_REQ_DEF);
  localparam int BCNT_W = clog2Min1(MAX_BURST_DEF);

  // OR of the set bit positions; exact for a one-hot input and 0 for all-zero.
  function automatic int onehotIdx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin search: first requester after lastOwner_i, wrapping,
// with lastOwner_i itself checked last.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IdxW    = clog2Min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    lastOwner_i,
  output logic               valid_o,
  output logic [IdxW-1:0]    idx_o
);

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    int cand;
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(lastOwner_i) + k) % NUM_REQ;
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, with bursts
// of up to MAX_BURST words per grant. Define FIFO_ARB_STATS_EN to add STAT_CNT counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          W_CLK,
  input  logic                          W_RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [NUM_REQ-1:0]            ACK,
  input  logic                          FULL,
  output logic                          W_INC,
  output logic [DATA_WIDTH-1:0]         WR_DATA
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  STAT_CNT
`endif
);

  localparam int IdxW  = clog2Min1(NUM_REQ);
  localparam int BcntW = clog2Min1(MAX_BURST);
  localparam logic [BcntW-1:0] BurstLast = BcntW'(MAX_BURST - 1);
  localparam logic [IdxW-1:0]  ResetLast = IdxW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 32 || MAX_BURST < 1 || DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : gBadParam
    $error("fifo_wr_arbiter: unsupported parameter set");
  end

  arbState_e          state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [BcntW-1:0]   bcnt_q, bcnt_d;
  logic [IdxW-1:0]    lastOwner_q, lastOwner_d;

  logic [IdxW-1:0]    owner;
  logic [IdxW-1:0]    pickLast;
  logic [IdxW-1:0]    pickIdx;
  logic               pickValid;
  logic               ownerReq;
  logic               wInc;
  logic               releaseEv;
  logic [NUM_REQ-1:0] ack;

  assign owner    = IdxW'(onehotIdx(32'(gnt_q)));
  assign ownerReq = REQ[owner];
  assign wInc     = (state_q == OWN) && ownerReq && !FULL;
  assign ack      = gnt_q & {NUM_REQ{wInc}};

  assign GNT     = gnt_q;
  assign ACK     = ack;
  assign W_INC   = wInc;
  assign WR_DATA = (state_q == OWN) ? REQ_DATA[owner*DATA_WIDTH +: DATA_WIDTH] : '0;

  // On release the search restarts just after the current owner, which is what last_owner becomes.
  assign pickLast  = (state_q == OWN) ? owner : lastOwner_q;
  assign releaseEv = (state_q == OWN) && ((wInc && (bcnt_q == BurstLast)) || !ownerReq);

  fifo_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) uPick (
    .req_i       (REQ),
    .lastOwner_i (pickLast),
    .valid_o     (pickValid),
    .idx_o       (pickIdx)
  );

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      bcnt_q      <= '0;
      lastOwner_q <= ResetLast;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      bcnt_q      <= bcnt_d;
      lastOwner_q <= lastOwner_d;
    end
  end

  // A FULL stall with REQ still held falls through every branch and holds all state.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    bcnt_d      = bcnt_q;
    lastOwner_d = lastOwner_q;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d = OWN;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pickIdx;
          bcnt_d  = '0;
        end
      end
      OWN: begin
        if (releaseEv) begin
          lastOwner_d = owner;
          bcnt_d      = '0;
          if (pickValid) begin
            gnt_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pickIdx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (wInc) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        bcnt_d  = '0;
      end
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : gStat
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
        cnt_q <= '0;
      end else if (ack[i]) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign STAT_CNT[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`endif

endmodule
